// File: rtl/spi_adc_amp_responder_pkg.sv
// rtl/spi_adc_amp_responder_pkg.sv - shared sizes, ADC state type and frame builder
package spi_adc_amp_responder_pkg;

   localparam int AMP_BITS  = 8;
   localparam int ADC_BITS  = 14;
   localparam int ADC_GAP   = 2;
   localparam int ADC_FRAME = 3 * ADC_GAP + 2 * ADC_BITS;
   localparam int GAIN_BITS = AMP_BITS / 2;
   localparam int CNT_BITS  = $clog2(ADC_FRAME + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } adc_state_t;

   // Serial frame image, MSB leaves the device first: gap, A, gap, B, gap.
   function automatic logic [ADC_FRAME-1:0] build_frame(
      input logic [ADC_BITS-1:0] a,
      input logic [ADC_BITS-1:0] b
   );
      return {{ADC_GAP{1'b0}}, a, {ADC_GAP{1'b0}}, b, {ADC_GAP{1'b0}}};
   endfunction

endpackage

// File: rtl/spi_adc_amp_responder_if.sv
// rtl/spi_adc_amp_responder_if.sv - pin bundle shared by the amp/adc controllers and the responder
interface spi_adc_amp_responder_if;
   import spi_adc_amp_responder_pkg::*;

   logic                 spi_sck;
   logic                 spi_mosi;
   logic                 amp_cs;
   logic                 amp_shdn;
   logic                 amp_dout;
   logic                 adc_conv;
   logic                 adc_out;
   logic [ADC_BITS-1:0]  sample_a;
   logic [ADC_BITS-1:0]  sample_b;
   logic [GAIN_BITS-1:0] gain_a;
   logic [GAIN_BITS-1:0] gain_b;
   logic                 gain_valid;
   logic                 adc_busy;
   logic                 frame_done;

   modport master (
      output spi_sck, spi_mosi, amp_cs, amp_shdn, adc_conv, sample_a, sample_b,
      input  amp_dout, adc_out, gain_a, gain_b, gain_valid, adc_busy, frame_done
   );

   modport slave (
      input  spi_sck, spi_mosi, amp_cs, amp_shdn, adc_conv, sample_a, sample_b,
      output amp_dout, adc_out, gain_a, gain_b, gain_valid, adc_busy, frame_done
   );

endinterface

// File: rtl/spi_adc_amp_responder_sck_edge_detect.sv
// rtl/spi_adc_amp_responder_sck_edge_detect.sv - single-register sampler with rise/fall pulses
module sck_edge_detect (
   input  logic clk,
   input  logic resetn,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);

   logic q;
   logic q_prev;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         q      <= 1'b0;
         q_prev <= 1'b0;
      end else begin
         q      <= d;
         q_prev <= q;
      end
   end

   assign level = q;
   assign rise  = q & ~q_prev;
   assign fall  = ~q & q_prev;

endmodule

// File: rtl/spi_adc_amp_responder.sv
// rtl/spi_adc_amp_responder.sv - device-side model of the LTC6912-1 preamp and LTC1407A-1 dual ADC
module spi_adc_amp_responder
   import spi_adc_amp_responder_pkg::*;
(
   input  logic                     CLK50MHZ,
   input  logic                     RST,
   spi_adc_amp_responder_if.slave   bus
);

   localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(ADC_FRAME - 1);

   logic sck_level, sck_rise, sck_fall;
   logic cs_level, cs_rise, cs_fall;
   logic conv_level, conv_rise, conv_fall;

   sck_edge_detect u_sck_edge (
      .clk    (CLK50MHZ),
      .resetn (RST),
      .d      (bus.spi_sck),
      .level  (sck_level),
      .rise   (sck_rise),
      .fall   (sck_fall)
   );

   sck_edge_detect u_cs_edge (
      .clk    (CLK50MHZ),
      .resetn (RST),
      .d      (bus.amp_cs),
      .level  (cs_level),
      .rise   (cs_rise),
      .fall   (cs_fall)
   );

   sck_edge_detect u_conv_edge (
      .clk    (CLK50MHZ),
      .resetn (RST),
      .d      (bus.adc_conv),
      .level  (conv_level),
      .rise   (conv_rise),
      .fall   (conv_fall)
   );

   logic unused_edges;
   assign unused_edges = &{1'b0, sck_level, cs_fall, conv_level, conv_fall};

   logic [AMP_BITS-1:0]  amp_sreg;
   logic [GAIN_BITS-1:0] gain_a_q;
   logic [GAIN_BITS-1:0] gain_b_q;
   logic                 gain_valid_q;
   logic                 amp_dout_q;

   // Echo is taken from sreg[7] on the fall, so the old register leaves MSB first during the next write.
   always_ff @(posedge CLK50MHZ) begin
      if (!RST) begin
         amp_sreg     <= '0;
         gain_a_q     <= '0;
         gain_b_q     <= '0;
         gain_valid_q <= 1'b0;
         amp_dout_q   <= 1'b0;
      end else begin
         gain_valid_q <= 1'b0;
         if (bus.amp_shdn) begin
            amp_sreg <= '0;
            gain_a_q <= '0;
            gain_b_q <= '0;
         end else begin
            if (!cs_level && sck_rise) begin
               amp_sreg <= {amp_sreg[AMP_BITS-2:0], bus.spi_mosi};
            end
            if (!cs_level && sck_fall) begin
               amp_dout_q <= amp_sreg[AMP_BITS-1];
            end
            if (cs_rise) begin
               {gain_b_q, gain_a_q} <= amp_sreg;
               gain_valid_q         <= 1'b1;
            end
         end
      end
   end

   assign bus.amp_dout   = amp_dout_q;
   assign bus.gain_a     = gain_a_q;
   assign bus.gain_b     = gain_b_q;
   assign bus.gain_valid = gain_valid_q;

   adc_state_t            state;
   adc_state_t            next_state;
   logic [ADC_FRAME-1:0]  frame;
   logic [CNT_BITS-1:0]   cnt;
   logic                  adc_out_q;

   always_ff @(posedge CLK50MHZ) begin
      if (!RST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (conv_rise) begin
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            if (conv_rise) begin
               next_state = SHIFT;
            end else if (sck_fall && cnt == LAST_CNT) begin
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = conv_rise ? SHIFT : IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Frame is shifted left so the outgoing bit is always the MSB; a new conv restarts mid-frame.
   always_ff @(posedge CLK50MHZ) begin
      if (!RST) begin
         frame     <= '0;
         cnt       <= '0;
         adc_out_q <= 1'b0;
      end else if (conv_rise) begin
         frame <= build_frame(bus.sample_a, bus.sample_b);
         cnt   <= '0;
      end else if (state == SHIFT && sck_fall) begin
         cnt       <= cnt + 1'b1;
         adc_out_q <= frame[ADC_FRAME-1];
         frame     <= {frame[ADC_FRAME-2:0], 1'b0};
      end
   end

   always_comb begin
      bus.adc_busy   = 1'b0;
      bus.frame_done = 1'b0;
      bus.adc_out    = 1'b0;
      case (state)
         SHIFT: begin
            bus.adc_busy = 1'b1;
            bus.adc_out  = adc_out_q;
         end
         DONE: begin
            bus.frame_done = 1'b1;
            bus.adc_out    = adc_out_q;
         end
         default: ;
      endcase
   end

endmodule
